// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ctrl_pkg                                                  |
// | Purpose  : Shared types for the multicycle accumulator-CPU           |
// |            controller: opcode enum, one-hot state enum and the       |
// |            memory-op classifier.                                     |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package ctrl_pkg;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } op_e;

  typedef enum logic [6:0] {
    S_FETCH  = 7'b000_0001,
    S_DECODE = 7'b000_0010,
    S_EXEC   = 7'b000_0100,
    S_WB     = 7'b000_1000,
    S_SKIP   = 7'b001_0000,
    S_HALTED = 7'b010_0000,
    S_ERROR  = 7'b100_0000
  } state_e;

  // Opcodes that touch data memory during EXEC.
  function automatic logic is_mem_op(input op_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) ||
           (op == OP_LDA) || (op == OP_STO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wait_timer                                                |
// | Purpose  : Memory wait-state counter shared by FETCH and EXEC.       |
// |            Saturating count, synchronous clear, and an "expired"     |
// |            flag meaning the current wait cycle is the last one       |
// |            allowed before the bus times out.                         |
// | Ports    : clk, rst (async, active-high), clr_i, en_i, expired_o     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module wait_timer #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // A zero limit still needs a legal 1-bit counter.
  localparam int unsigned CNT_W = (WAIT_LIMIT == 0) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  generate
    if (WAIT_LIMIT == 0) begin : g_no_timeout
      assign expired_o = 1'b0;
    end else begin : g_timeout
      // A not-ready cycle seen with WAIT_LIMIT-1 waits already counted
      // would push the count to WAIT_LIMIT: that is the timeout.
      localparam logic [CNT_W-1:0] LAST_OK = CNT_W'(WAIT_LIMIT - 1);
      assign expired_o = (cnt_q == LAST_OK);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : multicycle_ctrl                                           |
// | Purpose  : Multicycle controller for the 8-opcode accumulator ISA.   |
// |            Sequences FETCH/DECODE/EXEC/WB with memory handshakes,    |
// |            bus timeout, skip-on-zero, halt/resume and a retired-     |
// |            instruction counter.                                      |
// | Ports    : clk, rst (async, active-high)                             |
// |            in : opcode, is_zero, imem_ready, dmem_ready, resume      |
// |            out: imem_req, dmem_req, dmem_we, acc_load, acc_sel,      |
// |                 pc_en, pc_load, jmp, halted, err, retired            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned OPW        = 3,
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned RET_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   opcode,
  input  logic             is_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             resume,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             acc_load,
  output logic             acc_sel,
  output logic             pc_en,
  output logic             pc_load,
  output logic             jmp,
  output logic             halted,
  output logic             err,
  output logic [RET_W-1:0] retired
);

  state_e           state_q;
  logic [OPW-1:0]   ir_op_q;
  logic [RET_W-1:0] retired_q;

  op_e  w_op;
  logic w_op_legal;
  logic w_op_mem, w_op_hlt, w_op_skz, w_op_jmp, w_op_lda, w_op_sto;
  logic w_exec_mem;
  logic w_tmr_clr, w_tmr_en, w_tmr_expired;

  // Codes above 7 (only possible when OPW > 3) decode as NOP.
  generate
    if (OPW > 3) begin : g_wide_op
      assign w_op_legal = (ir_op_q[OPW-1:3] == '0);
    end else begin : g_narrow_op
      assign w_op_legal = 1'b1;
    end
  endgenerate

  assign w_op     = op_e'(ir_op_q[2:0]);
  assign w_op_mem = w_op_legal && is_mem_op(w_op);
  assign w_op_hlt = w_op_legal && (w_op == OP_HLT);
  assign w_op_skz = w_op_legal && (w_op == OP_SKZ);
  assign w_op_jmp = w_op_legal && (w_op == OP_JMP);
  assign w_op_lda = w_op_legal && (w_op == OP_LDA);
  assign w_op_sto = w_op_legal && (w_op == OP_STO);

  assign w_exec_mem = (state_q == S_EXEC) && w_op_mem;

  // One counter serves both memory ports; only one is ever requesting.
  assign w_tmr_clr = ((state_q == S_FETCH) && imem_ready) || (w_exec_mem && dmem_ready);
  assign w_tmr_en  = ((state_q == S_FETCH) && !imem_ready) || (w_exec_mem && !dmem_ready);

  wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (w_tmr_clr),
    .en_i      (w_tmr_en),
    .expired_o (w_tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_op_q   <= '0;
      retired_q <= '0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (imem_ready) begin
            ir_op_q <= opcode;
            state_q <= S_DECODE;
          end else if (w_tmr_expired) begin
            state_q <= S_ERROR;
          end
        end
        S_DECODE: state_q <= S_EXEC;
        S_EXEC: begin
          if (w_op_mem) begin
            // Ready wins over expiry: the last allowed wait cycle still succeeds.
            if (dmem_ready) begin
              state_q <= S_WB;
            end else if (w_tmr_expired) begin
              state_q <= S_ERROR;
            end
          end else if (w_op_hlt) begin
            state_q <= S_HALTED;
          end else begin
            state_q <= S_WB;
          end
        end
        S_WB: begin
          retired_q <= retired_q + 1'b1;
          if (!w_op_jmp && w_op_skz && is_zero) begin
            state_q <= S_SKIP;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_SKIP:   state_q <= S_FETCH;
        S_HALTED: if (resume) state_q <= S_WB;
        S_ERROR:  state_q <= S_ERROR;
        default:  state_q <= S_ERROR;
      endcase
    end
  end

  // Outputs are forced low while reset is held, since the reset state
  // (FETCH) would otherwise already be requesting.
  assign imem_req = !rst && (state_q == S_FETCH);
  assign dmem_req = !rst && w_exec_mem;
  assign dmem_we  = !rst && w_exec_mem && w_op_sto;
  assign acc_load = !rst && w_exec_mem && dmem_ready && !w_op_sto;
  assign acc_sel  = !rst && w_exec_mem && dmem_ready && w_op_lda;
  assign pc_en    = !rst && (((state_q == S_WB) && !w_op_jmp) || (state_q == S_SKIP));
  assign pc_load  = !rst && (state_q == S_WB) && w_op_jmp;
  assign jmp      = !rst && (state_q == S_WB) && w_op_jmp;
  assign halted   = !rst && (state_q == S_HALTED);
  assign err      = !rst && (state_q == S_ERROR);
  assign retired  = (rst || (state_q == S_ERROR)) ? '0 : retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_multicycle_ctrl                                        |
// | Purpose  : Self-checking bench for multicycle_ctrl. An instruction-  |
// |            level model expands each instruction into its expected    |
// |            per-cycle output trace and input stimulus.                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_multicycle_ctrl;

  localparam int OPW = 4;
  localparam int WL  = 4;
  localparam int RW  = 4;

  // Output vector bit masks {imem_req,dmem_req,dmem_we,acc_load,acc_sel,pc_en,pc_load,jmp,halted,err}
  localparam logic [9:0] IMREQ = 10'b10_0000_0000;
  localparam logic [9:0] DMREQ = 10'b01_0000_0000;
  localparam logic [9:0] WE    = 10'b00_1000_0000;
  localparam logic [9:0] ACCL  = 10'b00_0100_0000;
  localparam logic [9:0] ACCS  = 10'b00_0010_0000;
  localparam logic [9:0] PCEN  = 10'b00_0001_0000;
  localparam logic [9:0] PCLD  = 10'b00_0000_1000;
  localparam logic [9:0] JMPB  = 10'b00_0000_0100;
  localparam logic [9:0] HALT  = 10'b00_0000_0010;
  localparam logic [9:0] ERRB  = 10'b00_0000_0001;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [OPW-1:0] opcode = '0;
  logic           is_zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0, resume = 1'b0;
  logic           imem_req, dmem_req, dmem_we, acc_load, acc_sel;
  logic           pc_en, pc_load, jmp, halted, err;
  logic [RW-1:0]  retired;

  multicycle_ctrl #(.OPW(OPW), .WAIT_LIMIT(WL), .RET_W(RW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .is_zero(is_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .resume(resume),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .acc_load(acc_load), .acc_sel(acc_sel), .pc_en(pc_en), .pc_load(pc_load),
    .jmp(jmp), .halted(halted), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            imr, dmr, isz, res;
    logic [3:0]    opc;
    logic [9:0]    exp;
    logic [RW-1:0] ret;
  } rec_t;

  rec_t tr[$];
  int   m_ret;
  int   checks = 0;
  int   errors = 0;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] r4();
    return 4'($urandom);
  endfunction

  // Retired count reads as zero whenever the controller is in its error state.
  function automatic void push(bit imr, bit dmr, logic [3:0] opc, bit isz, bit res, logic [9:0] e);
    rec_t r;
    r.imr = imr; r.dmr = dmr; r.opc = opc; r.isz = isz; r.res = res; r.exp = e;
    r.ret = (e & ERRB) != 0 ? '0 : RW'(m_ret);
    tr.push_back(r);
  endfunction

  // Expand one instruction into cycles. wi/wd: wait cycles on imem/dmem;
  // z: is_zero at writeback; hold: extra halted cycles before resume.
  // Unused inputs carry random noise that the controller must ignore.
  function automatic void gen_instr(logic [3:0] op, int wi, int wd, bit z, int hold);
    bit is_mem = (op >= 2) && (op <= 6);
    logic [9:0] d;
    for (int i = 0; i < wi; i++) push(1'b0, rb(), r4(), rb(), rb(), IMREQ);
    push(1'b1, rb(), op, rb(), rb(), IMREQ);
    push(rb(), rb(), r4(), rb(), rb(), '0);                 // decode
    if (is_mem) begin
      d = DMREQ | ((op == 6) ? WE : '0);
      for (int i = 0; i < wd; i++) push(rb(), 1'b0, r4(), rb(), rb(), d);
      push(rb(), 1'b1, r4(), rb(), rb(),
           d | ((op != 6) ? ACCL : '0) | ((op == 5) ? ACCS : '0));
    end else if (op == 0) begin
      push(rb(), rb(), r4(), rb(), 1'b1, '0);               // resume on entry cycle: ignored
      for (int i = 0; i < hold; i++) push(rb(), rb(), r4(), rb(), 1'b0, HALT);
      push(rb(), rb(), r4(), rb(), 1'b1, HALT);
    end else begin
      push(rb(), rb(), r4(), rb(), rb(), '0);
    end
    push(rb(), rb(), r4(), z, rb(), (op == 7) ? (PCLD | JMPB) : PCEN);
    m_ret++;
    if (op == 1 && z) push(rb(), rb(), r4(), rb(), rb(), PCEN);
  endfunction

  // Apply one cycle of stimulus (called just after a rising edge) and
  // sample outputs at the falling edge.
  task automatic drive(input rec_t r, output logic [9:0] o, output logic [RW-1:0] rt);
    imem_ready = r.imr; dmem_ready = r.dmr; opcode = r.opc; is_zero = r.isz; resume = r.res;
    @(negedge clk);
    o  = {imem_req, dmem_req, dmem_we, acc_load, acc_sel, pc_en, pc_load, jmp, halted, err};
    rt = retired;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] o;
    rst = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; resume = 1'b1; opcode = 4'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    o = {imem_req, dmem_req, dmem_we, acc_load, acc_sel, pc_en, pc_load, jmp, halted, err};
    checks++;
    if (o !== '0 || retired !== '0) begin
      errors++;
      $display("FAIL reset: got out=%b ret=%0d, expected out=0 ret=0", o, retired);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ret = 0;
  endtask

  task automatic test_lda();
    logic [9:0] o; logic [RW-1:0] rt;
    gen_instr(4'd5, 0, 0, rb(), 0);
    foreach (tr[i]) begin
      drive(tr[i], o, rt);
      checks++;
      if ({o, rt} !== {tr[i].exp, tr[i].ret}) begin
        errors++;
        $display("FAIL lda cyc%0d: got out=%b ret=%0d, expected out=%b ret=%0d", i, o, rt, tr[i].exp, tr[i].ret);
      end
    end
    tr.delete();
  endtask

  task automatic test_sto_wait();
    logic [9:0] o; logic [RW-1:0] rt;
    gen_instr(4'd6, 0, 3, rb(), 0);
    gen_instr(4'd2, WL - 1, WL - 1, rb(), 0);   // longest wait that still succeeds
    foreach (tr[i]) begin
      drive(tr[i], o, rt);
      checks++;
      if ({o, rt} !== {tr[i].exp, tr[i].ret}) begin
        errors++;
        $display("FAIL sto_wait cyc%0d: got out=%b ret=%0d, expected out=%b ret=%0d", i, o, rt, tr[i].exp, tr[i].ret);
      end
    end
    tr.delete();
  endtask

  task automatic test_skz_jmp();
    logic [9:0] o; logic [RW-1:0] rt;
    gen_instr(4'd1, 0, 0, 1'b1, 0);
    gen_instr(4'd1, 1, 0, 1'b0, 0);
    gen_instr(4'd7, 0, 0, 1'b1, 0);
    gen_instr(4'd9, 0, 0, 1'b1, 0);             // wide code: NOP
    foreach (tr[i]) begin
      drive(tr[i], o, rt);
      checks++;
      if ({o, rt} !== {tr[i].exp, tr[i].ret}) begin
        errors++;
        $display("FAIL skz_jmp cyc%0d: got out=%b ret=%0d, expected out=%b ret=%0d", i, o, rt, tr[i].exp, tr[i].ret);
      end
    end
    tr.delete();
  endtask

  task automatic test_halt();
    logic [9:0] o; logic [RW-1:0] rt;
    gen_instr(4'd0, 0, 0, rb(), 20);
    gen_instr(4'd3, 0, 0, rb(), 0);
    foreach (tr[i]) begin
      drive(tr[i], o, rt);
      checks++;
      if ({o, rt} !== {tr[i].exp, tr[i].ret}) begin
        errors++;
        $display("FAIL halt cyc%0d: got out=%b ret=%0d, expected out=%b ret=%0d", i, o, rt, tr[i].exp, tr[i].ret);
      end
    end
    tr.delete();
  endtask

  task automatic test_back_to_back();
    logic [9:0] o; logic [RW-1:0] rt;
    for (int n = 0; n < 40; n++)
      gen_instr(r4(), $urandom_range(0, WL - 1), $urandom_range(0, WL - 1), rb(), $urandom_range(0, 3));
    foreach (tr[i]) begin
      drive(tr[i], o, rt);
      checks++;
      if ({o, rt} !== {tr[i].exp, tr[i].ret}) begin
        errors++;
        $display("FAIL random cyc%0d: got out=%b ret=%0d, expected out=%b ret=%0d", i, o, rt, tr[i].exp, tr[i].ret);
      end
    end
    tr.delete();
  endtask

  task automatic test_timeout();
    logic [9:0] o; logic [RW-1:0] rt;
    // Instruction fetch never completes.
    for (int i = 0; i < WL; i++) push(1'b0, rb(), r4(), rb(), rb(), IMREQ);
    for (int i = 0; i < 6; i++) push(rb(), rb(), r4(), rb(), rb(), ERRB);
    foreach (tr[i]) begin
      drive(tr[i], o, rt);
      checks++;
      if ({o, rt} !== {tr[i].exp, tr[i].ret}) begin
        errors++;
        $display("FAIL imem_timeout cyc%0d: got out=%b ret=%0d, expected out=%b ret=%0d", i, o, rt, tr[i].exp, tr[i].ret);
      end
    end
    tr.delete();
    // Asynchronous reset out of ERROR, checked before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    o = {imem_req, dmem_req, dmem_we, acc_load, acc_sel, pc_en, pc_load, jmp, halted, err};
    checks++;
    if (o !== '0 || retired !== '0) begin
      errors++;
      $display("FAIL err_reset: got out=%b ret=%0d, expected out=0 ret=0", o, retired);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ret = 0;
    // Data access never completes.
    push(1'b1, rb(), 4'd4, rb(), rb(), IMREQ);
    push(rb(), rb(), r4(), rb(), rb(), '0);
    for (int i = 0; i < WL; i++) push(rb(), 1'b0, r4(), rb(), rb(), DMREQ);
    for (int i = 0; i < 3; i++) push(rb(), rb(), r4(), rb(), rb(), ERRB);
    foreach (tr[i]) begin
      drive(tr[i], o, rt);
      checks++;
      if ({o, rt} !== {tr[i].exp, tr[i].ret}) begin
        errors++;
        $display("FAIL dmem_timeout cyc%0d: got out=%b ret=%0d, expected out=%b ret=%0d", i, o, rt, tr[i].exp, tr[i].ret);
      end
    end
    tr.delete();
  endtask

  initial begin
    test_reset();
    test_lda();
    test_sto_wait();
    test_skz_jmp();
    test_halt();
    test_back_to_back();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle CPU controller, successor to the fixed four-phase control FSM. Drives PC, accumulator and split instruction/data memories for the 8-opcode accumulator ISA. Adds:
- req/ready memory handshakes with wait states and a bus timeout
- a true skip-on-zero (double PC increment)
- halt with resume
- a retired-instruction counter

Sits between the PC/IR/ACC datapath and the two memory ports.

## Interface
Parameters:
- OPW, 3: opcode width (≥3); codes ≥8 execute as NOP
- WAIT_LIMIT, 15: max wait cycles per memory access before timeout; 0 disables the timeout
- RET_W, 16: retired-instruction counter width

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  OPW  instruction opcode; valid in the cycle imem_ready=1
- is_zero  in  1  accumulator-zero flag; sampled in WB
- imem_ready  in  1  instruction-memory access complete
- dmem_ready  in  1  data-memory access complete
- resume  in  1  leave HALTED; ignored in all other states
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data-memory request
- dmem_we  out  1  data-memory write (STO only); qualifies dmem_req
- acc_load  out  1  load accumulator this cycle
- acc_sel  out  1  1: ACC←memory (LDA); 0: ACC←ALU result
- pc_en  out  1  PC increment
- pc_load  out  1  PC load from IR operand
- jmp  out  1  asserted with pc_load for JMP
- halted  out  1  in HALTED
- err  out  1  sticky timeout flag
- retired  out  RET_W  retired-instruction count

## Operation
- Opcodes (package enum): 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP. MEM ops are ADD, AND, XOR, LDA, STO.
- Opcode is latched into ir_op on the FETCH cycle with imem_ready=1. All decoding uses ir_op.
- States: FETCH, DECODE, EXEC, WB, SKIP, HALTED, ERROR. One-hot encoding.
- FETCH: imem_req=1.
  - imem_ready=1 → latch opcode, clear wait_cnt, go to DECODE.
  - Otherwise wait_cnt++.
- DECODE: one cycle, no outputs asserted, always → EXEC.
- EXEC, MEM op: dmem_req=1; dmem_we=1 for STO.
  - While dmem_ready=0: wait_cnt++.
  - On the dmem_ready=1 cycle: acc_load=1 for ADD/AND/XOR/LDA; acc_sel=1 for LDA only. Then → WB.
- EXEC, non-MEM op: one cycle.
  - HLT → HALTED.
  - All others → WB.
- WB: retired++ (wraps modulo 2^RET_W).
  - JMP: pc_load=1, jmp=1, → FETCH.
  - SKZ with is_zero=1: pc_en=1, → SKIP.
  - All other cases: pc_en=1, → FETCH.
- SKIP: pc_en=1, → FETCH.
- HALTED: halted=1.
  - resume=1 → WB, so the PC advances past the HLT and it is counted as retired.
- Timeout: WAIT_LIMIT≠0 and wait_cnt reaches WAIT_LIMIT with ready still 0 → ERROR.
- ERROR: err=1, all other outputs 0. Exited only by reset.
- wait_cnt is $clog2(WAIT_LIMIT+1) bits and saturates.

## Timing
- Reset (asynchronous) forces state=FETCH, wait_cnt=0, ir_op=0, retired=0. Every output is 0 while rst=1.
- Outputs are Moore decodes of state and ir_op, except the ready-qualified ones (acc_load, acc_sel), which are combinational in the ready cycle.
- Zero-wait instruction latency:
  - MEM/ALU ops and non-skipping SKZ: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Taken SKZ: 5 cycles.
  - HLT: reaches HALTED in 3 cycles.
- Each wait cycle adds one cycle.
- Ready seen in the first request cycle means zero waits.
- Reset deasserted: imem_req=1 in the first clock cycle.
- Reset mid-wait aborts the access. No request is held.
- resume and the HALTED entry in the same cycle: resume is ignored, since it is only sampled in HALTED.
- Ready asserted in a state not requesting that memory: ignored.
- A wait of exactly WAIT_LIMIT−1 cycles, followed by ready, succeeds. Ready on cycle WAIT_LIMIT+1 is too late (ERROR).

## Structure
- Package ctrl_pkg: opcode enum, state enum, is_mem_op() function.
- Sub-module wait_timer: wait counter with clear, count-enable, saturation and expired output. It is instantiated once and shared by FETCH and EXEC.

## Test plan
- Reset, then zero-wait LDA (opcode 5): imem_req at cycle 0; dmem_req plus acc_load/acc_sel=1 at cycle 2; pc_en at cycle 3; retired=1.
- STO with dmem_ready delayed 3 cycles: dmem_req/dmem_we held for 4 cycles, acc_load never asserted, retired=1.
- SKZ with is_zero=1: pc_en high for 2 consecutive cycles (WB, SKIP), 5-cycle instruction. With is_zero=0: a single pc_en.
- JMP: pc_load=jmp=1 for one cycle in WB, pc_en=0 throughout.
- HLT: halted stays 1 for 20 cycles with resume=0; a resume pulse gives one pc_en, then imem_req, retired+1.
- WAIT_LIMIT=4 with imem_ready held at 0: err=1 after 4 request cycles and stays sticky. Reset asserted mid-ERROR clears err and all outputs immediately.
